// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared digit constants and FSM encoding for the answer keeper
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int NUM_DIGITS_DEFAULT = 4;
  localparam int DIGIT_W            = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_READY = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/match_counter.sv
`default_nettype none
// ============================================================================
// match_counter : combinational strike/ball count of a guess against an answer
// Revision      : 1.0 - initial release
// ============================================================================
module match_counter
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] answer,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
  output logic [2:0]                    strikes,
  output logic [2:0]                    balls
);

  logic w_hit;

  // A zero guess digit is a blank and never scores.
  always_comb begin
    strikes = '0;
    balls   = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_hit = 1'b0;
      if (guess[i*DIGIT_W +: DIGIT_W] != '0) begin
        if (guess[i*DIGIT_W +: DIGIT_W] == answer[i*DIGIT_W +: DIGIT_W])
          strikes = strikes + 3'd1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if ((j != i) && (guess[i*DIGIT_W +: DIGIT_W] == answer[j*DIGIT_W +: DIGIT_W]))
            w_hit = 1'b1;
        end
        if (w_hit)
          balls = balls + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/answer_keeper.sv
`default_nettype none
// ============================================================================
// answer_keeper : builds a unique-digit answer from a random source and scores
//                 guesses against it with strikes and balls
// Revision      : 1.0 - initial release
// ============================================================================
module answer_keeper
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_game,
  output logic                          change_answer,
  input  logic                          write_enable,
  input  logic [31:0]                   rand_value,
  input  logic                          guess_valid,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
  output logic                          guess_ready,
  output logic                          result_valid,
  output logic [2:0]                    strikes,
  output logic [2:0]                    balls,
  output logic                          win,
  output logic [NUM_DIGITS*DIGIT_W-1:0] answer,
  output logic                          busy
);

  localparam int c_cnt_w = $clog2(NUM_DIGITS + 1);
  localparam int c_tmr_w = $clog2(TIMEOUT + 1);

  state_t                        r_state;
  logic [c_cnt_w-1:0]            r_count;
  logic [c_tmr_w-1:0]            r_timer;
  logic [DIGIT_W-1:0]            r_candidate;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_answer;
  logic                          r_change_answer;
  logic                          r_guess_ready;
  logic                          r_result_valid;
  logic                          r_win;
  logic                          r_busy;
  logic [2:0]                    r_strikes;
  logic [2:0]                    r_balls;

  logic [2:0] w_strikes;
  logic [2:0] w_balls;
  logic       w_dup;
  logic       w_cand_ok;
  logic       w_unused_rand;

  assign w_unused_rand = ^rand_value[31:DIGIT_W];

  match_counter #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_match_counter (
    .answer  (r_answer),
    .guess   (guess),
    .strikes (w_strikes),
    .balls   (w_balls)
  );

  // Unfilled slots hold 0, which is never a legal candidate, so scan them all.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_answer[i*DIGIT_W +: DIGIT_W] == r_candidate)
        w_dup = 1'b1;
    end
    w_cand_ok = (r_candidate >= DIGIT_MIN) && (r_candidate <= DIGIT_MAX) && !w_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_timer         <= '0;
      r_candidate     <= '0;
      r_answer        <= '0;
      r_change_answer <= 1'b0;
      r_guess_ready   <= 1'b0;
      r_result_valid  <= 1'b0;
      r_win           <= 1'b0;
      r_busy          <= 1'b0;
      r_strikes       <= '0;
      r_balls         <= '0;
    end else begin
      r_change_answer <= 1'b0;
      r_result_valid  <= 1'b0;
      if (new_game) begin
        r_answer        <= '0;
        r_count         <= '0;
        r_timer         <= '0;
        r_win           <= 1'b0;
        r_strikes       <= '0;
        r_balls         <= '0;
        r_state         <= ST_REQ;
        r_change_answer <= 1'b1;
        r_busy          <= 1'b1;
        r_guess_ready   <= 1'b0;
      end else begin
        case (r_state)
          ST_REQ: begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (write_enable) begin
              r_candidate <= rand_value[DIGIT_W-1:0];
              r_state     <= ST_CHECK;
            end else if (r_timer == c_tmr_w'(TIMEOUT - 1)) begin
              r_state         <= ST_REQ;
              r_change_answer <= 1'b1;
            end else begin
              r_timer <= r_timer + c_tmr_w'(1);
            end
          end
          ST_CHECK: begin
            if (w_cand_ok) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_count == c_cnt_w'(i))
                  r_answer[i*DIGIT_W +: DIGIT_W] <= r_candidate;
              end
              r_count <= r_count + c_cnt_w'(1);
            end
            if (w_cand_ok && (r_count == c_cnt_w'(NUM_DIGITS - 1))) begin
              r_state       <= ST_READY;
              r_guess_ready <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_state         <= ST_REQ;
              r_change_answer <= 1'b1;
            end
          end
          ST_READY: begin
            if (guess_valid) begin
              r_result_valid <= 1'b1;
              r_strikes      <= w_strikes;
              r_balls        <= w_balls;
              r_win          <= (w_strikes == 3'(NUM_DIGITS));
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign change_answer = r_change_answer;
  assign guess_ready   = r_guess_ready;
  assign result_valid  = r_result_valid;
  assign strikes       = r_strikes;
  assign balls         = r_balls;
  assign win           = r_win;
  assign answer        = r_answer;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_answer_keeper.sv
`default_nettype none
// ============================================================================
// tb_answer_keeper : directed self-checking bench for answer_keeper
// Revision         : 1.0 - initial release
// ============================================================================
module tb_answer_keeper;

  localparam int NUM_DIGITS = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst, new_game, write_enable, guess_valid;
  logic [31:0] rand_value;
  logic [15:0] guess;
  logic        change_answer, guess_ready, result_valid, win, busy;
  logic [2:0]  strikes, balls;
  logic [15:0] answer;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  answer_keeper #(
    .NUM_DIGITS (NUM_DIGITS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .new_game      (new_game),
    .change_answer (change_answer),
    .write_enable  (write_enable),
    .rand_value    (rand_value),
    .guess_valid   (guess_valid),
    .guess         (guess),
    .guess_ready   (guess_ready),
    .result_valid  (result_valid),
    .strikes       (strikes),
    .balls         (balls),
    .win           (win),
    .answer        (answer),
    .busy          (busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int limit, output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (!found && cycles < limit) begin
      if (change_answer === 1'b1) found = 1'b1;
      else begin tick(); cycles++; end
    end
  endtask

  // Generator model: answer a request after 'delay' cycles with digit v.
  task automatic reply(input int delay, input logic [3:0] v);
    tick(delay);
    write_enable = 1'b1;
    rand_value   = {28'hABCDE12, v};
    tick();
    write_enable = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; new_game = 0; write_enable = 0; guess_valid = 0; rand_value = 0; guess = 0;
    tick(3);
    n_cmp++; if (change_answer !== 1'b0) begin n_err++; $display("FAIL rst_change_answer: got %b expected 0", change_answer); end
    n_cmp++; if (guess_ready !== 1'b0) begin n_err++; $display("FAIL rst_guess_ready: got %b expected 0", guess_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL rst_result_valid: got %b expected 0", result_valid); end
    n_cmp++; if ({strikes, balls, win} !== 7'd0) begin n_err++; $display("FAIL rst_score: got s=%0d b=%0d w=%b expected 0", strikes, balls, win); end
    n_cmp++; if (answer !== 16'h0) begin n_err++; $display("FAIL rst_answer: got %h expected 0000", answer); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick(2);
    n_cmp++; if ({busy, change_answer} !== 2'b00) begin n_err++; $display("FAIL idle_hold: got busy=%b ca=%b expected 0 0", busy, change_answer); end
  endtask

  task automatic test_generation;
    logic [3:0] vals [5] = '{4'd3, 4'd5, 4'd3, 4'd7, 4'd1};
    int         dly  [5] = '{1, 2, 3, 2, 1};
    int cyc, pulses;
    bit found;
    pulses = 0;
    new_game = 1'b1; tick(); new_game = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gen_busy: got %b expected 1", busy); end
    for (int k = 0; k < 5; k++) begin
      wait_pulse(40, cyc, found);
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL gen_pulse%0d: got none expected change_answer", k); end
      else begin pulses++; reply(dly[k], vals[k]); end
    end
    for (int c = 0; c < 10 && guess_ready !== 1'b1; c++) begin
      if (change_answer === 1'b1) pulses++;
      tick();
    end
    n_cmp++; if (guess_ready !== 1'b1) begin n_err++; $display("FAIL gen_ready: got %b expected 1", guess_ready); end
    n_cmp++; if (answer !== 16'h1753) begin n_err++; $display("FAIL gen_answer: got %h expected 1753", answer); end
    n_cmp++; if (pulses != 5) begin n_err++; $display("FAIL gen_pulses: got %0d expected 5", pulses); end
    n_cmp++; if ({busy, change_answer} !== 2'b00) begin n_err++; $display("FAIL gen_idle_out: got busy=%b ca=%b expected 0 0", busy, change_answer); end
  endtask

  task automatic test_back_to_back_scoring;
    logic [15:0] g  [7] = '{16'h1753, 16'h3571, 16'h0003, 16'h1357, 16'h1753, 16'h9842, 16'h3333};
    logic [2:0]  es [7] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1};
    logic [2:0]  eb [7] = '{3'd0, 3'd4, 3'd0, 3'd2, 3'd0, 3'd0, 3'd3};
    logic        ew [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      guess = g[k]; guess_valid = 1'b1;
      tick();
      n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL score%0d_valid: got %b expected 1", k, result_valid); end
      n_cmp++; if (strikes !== es[k]) begin n_err++; $display("FAIL score%0d_strikes: got %0d expected %0d", k, strikes, es[k]); end
      n_cmp++; if (balls !== eb[k]) begin n_err++; $display("FAIL score%0d_balls: got %0d expected %0d", k, balls, eb[k]); end
      n_cmp++; if (win !== ew[k]) begin n_err++; $display("FAIL score%0d_win: got %b expected %b", k, win, ew[k]); end
    end
    guess_valid = 1'b0; guess = 16'h1753;
    tick(2);
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL score_idle_valid: got %b expected 0", result_valid); end
    n_cmp++; if ({strikes, balls, win} !== {3'd1, 3'd3, 1'b0}) begin n_err++; $display("FAIL score_hold: got s=%0d b=%0d w=%b expected 1 3 0", strikes, balls, win); end
  endtask

  task automatic test_timeout_reject;
    int cyc;
    bit found;
    new_game = 1'b1; tick(); new_game = 1'b0;
    n_cmp++; if (change_answer !== 1'b1) begin n_err++; $display("FAIL to_first_pulse: got %b expected 1", change_answer); end
    guess_valid = 1'b1; guess = 16'h0000;
    tick();
    wait_pulse(40, cyc, found);
    n_cmp++; if (!found || cyc != TIMEOUT) begin n_err++; $display("FAIL to_gap: got %0d expected %0d (found=%b)", cyc + 1, TIMEOUT + 1, found); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL to_guess_ignored: got %b expected 0", result_valid); end
    guess_valid = 1'b0;
    reply(1, 4'd0);
    wait_pulse(10, cyc, found);
    n_cmp++; if (!found || answer !== 16'h0) begin n_err++; $display("FAIL rej_zero: got %h found=%b expected 0000 found=1", answer, found); end
    reply(1, 4'd9);
    wait_pulse(10, cyc, found);
    n_cmp++; if (!found || answer !== 16'h0) begin n_err++; $display("FAIL rej_nine: got %h found=%b expected 0000 found=1", answer, found); end
    reply(1, 4'd4);
    wait_pulse(10, cyc, found);
    n_cmp++; if (!found || answer !== 16'h0004) begin n_err++; $display("FAIL acc_four: got %h found=%b expected 0004 found=1", answer, found); end
    // write_enable held across the REQ cycle must only take effect in WAIT
    write_enable = 1'b1; rand_value = 32'h6;
    tick();
    rand_value = 32'h2;
    tick();
    write_enable = 1'b0;
    wait_pulse(10, cyc, found);
    n_cmp++; if (!found || answer !== 16'h0024) begin n_err++; $display("FAIL we_outside_wait: got %h found=%b expected 0024 found=1", answer, found); end
  endtask

  task automatic test_priority;
    int cyc;
    bit found;
    reply(2, 4'd6);
    wait_pulse(10, cyc, found);
    reply(1, 4'd8);
    for (int c = 0; c < 10 && guess_ready !== 1'b1; c++) tick();
    n_cmp++; if (guess_ready !== 1'b1 || answer !== 16'h8624) begin n_err++; $display("FAIL pri_answer: got %h rdy=%b expected 8624 rdy=1", answer, guess_ready); end
    guess = 16'h8624; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    n_cmp++; if (win !== 1'b1) begin n_err++; $display("FAIL pri_win: got %b expected 1", win); end
    new_game = 1'b1; guess_valid = 1'b1;
    tick();
    new_game = 1'b0; guess_valid = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL pri_ng_guess_valid: got %b expected 0", result_valid); end
    n_cmp++; if (answer !== 16'h0) begin n_err++; $display("FAIL pri_ng_answer: got %h expected 0000", answer); end
    n_cmp++; if ({busy, guess_ready, win} !== 3'b100) begin n_err++; $display("FAIL pri_ng_flags: got busy=%b rdy=%b win=%b expected 1 0 0", busy, guess_ready, win); end
    tick();
    new_game = 1'b1; write_enable = 1'b1; rand_value = 32'h5;
    tick();
    new_game = 1'b0; write_enable = 1'b0;
    n_cmp++; if (change_answer !== 1'b1) begin n_err++; $display("FAIL pri_ng_we_req: got %b expected 1", change_answer); end
    tick(3);
    n_cmp++; if (answer !== 16'h0 || busy !== 1'b1) begin n_err++; $display("FAIL pri_ng_we_discard: got %h busy=%b expected 0000 busy=1", answer, busy); end
  endtask

  task automatic test_rst_mid_wait;
    rst = 1'b1; write_enable = 1'b1; rand_value = 32'h4;
    tick();
    write_enable = 1'b0;
    n_cmp++; if ({change_answer, guess_ready, result_valid, win, busy} !== 5'b0) begin n_err++; $display("FAIL rstw_flags: got %b expected 00000", {change_answer, guess_ready, result_valid, win, busy}); end
    n_cmp++; if ({strikes, balls} !== 6'd0 || answer !== 16'h0) begin n_err++; $display("FAIL rstw_data: got s=%0d b=%0d a=%h expected 0 0 0000", strikes, balls, answer); end
    rst = 1'b0; guess_valid = 1'b1; guess = 16'h1234;
    tick(2);
    guess_valid = 1'b0;
    n_cmp++; if ({result_valid, busy, change_answer} !== 3'b000 || answer !== 16'h0) begin n_err++; $display("FAIL rstw_idle: got rv=%b busy=%b ca=%b a=%h expected 0 0 0 0000", result_valid, busy, change_answer, answer); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_generation();
    test_back_to_back_scoring();
    test_timeout_reject();
    test_priority();
    test_rst_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
